// File: rtl/tff_bank_if.sv
// tff_bank_if: control, data and result signals of a tff_bank
interface tff_bank_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    modport master (output en, mode, t, d, input q, tc);
    modport slave  (input en, mode, t, d, output q, tc);
endinterface

// File: rtl/tff_bank.sv
// tff_bank: WIDTH-bit T flip-flop bank with toggle, up/down count and load modes
module tff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic       clk,
    input logic       rst,
    tff_bank_if.slave b
);
    localparam logic [1:0] TOG = 2'b00, UP = 2'b01, DN = 2'b10;
    localparam int LG = $clog2(WIDTH);
    logic [WIDTH-1:0] q, ones, zeros, tv;
    logic             tc;
    // ones[i] = &q[i:0] and zeros[i] = ~|q[i:0], built as a log-depth prefix AND
    always_comb begin
        ones  = q;
        zeros = ~q;
        for (int k = 0; k < LG; k++) begin
            ones  = ones  & ((ones  << (1 << k)) | ((WIDTH'(1) << (1 << k)) - WIDTH'(1)));
            zeros = zeros & ((zeros << (1 << k)) | ((WIDTH'(1) << (1 << k)) - WIDTH'(1)));
        end
    end
    // load is expressed as a toggle of every bit that differs from d
    always_comb tv = b.mode == TOG ? b.t :
                     b.mode == UP  ? {ones[WIDTH-2:0], 1'b1} :
                     b.mode == DN  ? {zeros[WIDTH-2:0], 1'b1} : q ^ b.d;
    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= RST_VAL;
            tc <= 1'b0;
        end else begin
            tc <= b.en && (b.mode == UP ? ones[WIDTH-1] : b.mode == DN ? zeros[WIDTH-1] : 1'b0);
            if (b.en) q <= q ^ tv;
        end
    end
    assign b.q  = q;
    assign b.tc = tc;
endmodule

// File: tb/tb_tff_bank.sv
// tb_tff_bank: directed and randomised checks of tff_bank against a behavioural model
module tb_tff_bank;
    localparam logic [1:0] TOG = 2'd0, UP = 2'd1, DN = 2'd2, LD = 2'd3;
    localparam logic [7:0] R8 = 8'hA5;
    logic clk = 1'b0, rst4 = 1'b0, rst8 = 1'b0;
    int   checks = 0, failures = 0;
    logic [3:0] m4q;
    logic [7:0] m8q;
    logic       m4tc, m8tc, v4 = 1'b0, v8 = 1'b0;

    tff_bank_if #(.WIDTH(4)) i4 ();
    tff_bank_if #(.WIDTH(8)) i8 ();
    tff_bank #(.WIDTH(4), .RST_VAL(4'h5)) u4 (.clk(clk), .rst(rst4), .b(i4));
    tff_bank #(.WIDTH(8), .RST_VAL(R8))   u8 (.clk(clk), .rst(rst8), .b(i8));

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
        end
    endfunction

    // reference: counters as plain modular arithmetic, wrap detected from the old value
    always @(posedge clk) begin
        if (rst4) begin
            m4q <= 4'h5; m4tc <= 1'b0; v4 <= 1'b1;
        end else if (!i4.en) m4tc <= 1'b0;
        else case (i4.mode)
            TOG: begin m4q <= m4q ^ i4.t;  m4tc <= 1'b0; end
            UP:  begin m4q <= m4q + 4'd1;  m4tc <= (m4q == 4'd15); end
            DN:  begin m4q <= m4q - 4'd1;  m4tc <= (m4q == 4'd0); end
            default: begin m4q <= i4.d;   m4tc <= 1'b0; end
        endcase
        if (rst8) begin
            m8q <= R8; m8tc <= 1'b0; v8 <= 1'b1;
        end else if (!i8.en) m8tc <= 1'b0;
        else case (i8.mode)
            TOG: begin m8q <= m8q ^ i8.t;  m8tc <= 1'b0; end
            UP:  begin m8q <= m8q + 8'd1;  m8tc <= (m8q == 8'd255); end
            DN:  begin m8q <= m8q - 8'd1;  m8tc <= (m8q == 8'd0); end
            default: begin m8q <= i8.d;   m8tc <= 1'b0; end
        endcase
    end

    always @(negedge clk) begin
        if (v4) begin
            chk("model4_q", 32'(i4.q), 32'(m4q));
            chk("model4_tc", 32'(i4.tc), 32'(m4tc));
        end
        if (v8) begin
            chk("model8_q", 32'(i8.q), 32'(m8q));
            chk("model8_tc", 32'(i8.tc), 32'(m8tc));
        end
    end

    task automatic drv4(input logic r, input logic e, input logic [1:0] m,
                        input logic [3:0] tt, input logic [3:0] dd);
        @(negedge clk);
        rst4 = r; i4.en = e; i4.mode = m; i4.t = tt; i4.d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(string n, logic [3:0] eq, logic etc);
        chk({n, "_q"}, 32'(i4.q), 32'(eq));
        chk({n, "_tc"}, 32'(i4.tc), 32'(etc));
    endtask

    initial begin
        i4.en = 1'b0; i4.mode = TOG; i4.t = '0; i4.d = '0;
        i8.en = 1'b0; i8.mode = TOG; i8.t = '0; i8.d = '0;
        drv4(1, 1, UP, 0, 0);   lit("rst_a", 4'h5, 0);
        drv4(1, 1, UP, 0, 0);   lit("rst_b", 4'h5, 0);
        drv4(0, 1, UP, 0, 0);   lit("rst_rel", 4'h6, 0);
        drv4(0, 1, LD, 0, 0);   lit("ld0", 4'h0, 0);
        drv4(0, 1, TOG, 4'hA, 0); lit("tog_a", 4'hA, 0);
        drv4(0, 1, TOG, 4'hA, 0); lit("tog_b", 4'h0, 0);
        drv4(0, 1, TOG, 4'hF, 0); lit("tog_f", 4'hF, 0);
        drv4(0, 0, TOG, 4'hF, 0); lit("en_off", 4'hF, 0);
        drv4(0, 1, LD, 0, 4'hE); lit("up_ld", 4'hE, 0);
        drv4(0, 1, UP, 0, 0);   lit("up_1", 4'hF, 0);
        drv4(0, 1, UP, 0, 0);   lit("up_wrap", 4'h0, 1);
        drv4(0, 1, UP, 0, 0);   lit("up_3", 4'h1, 0);
        drv4(0, 1, LD, 0, 4'h1); lit("dn_ld", 4'h1, 0);
        drv4(0, 1, DN, 0, 0);   lit("dn_1", 4'h0, 0);
        drv4(0, 1, DN, 0, 0);   lit("dn_wrap", 4'hF, 1);
        drv4(0, 1, DN, 0, 0);   lit("dn_3", 4'hE, 0);
        drv4(0, 1, LD, 0, 4'hF); lit("rw_ld", 4'hF, 0);
        drv4(1, 1, UP, 0, 0);   lit("rst_wrap", 4'h5, 0);
        drv4(0, 1, LD, 0, 4'h0); lit("alt_ld", 4'h0, 0);
        drv4(0, 1, UP, 0, 0);   lit("alt_1", 4'h1, 0);
        drv4(0, 1, DN, 0, 0);   lit("alt_2", 4'h0, 0);
        drv4(0, 1, DN, 0, 0);   lit("alt_3", 4'hF, 1);
        drv4(0, 1, UP, 0, 0);   lit("alt_4", 4'h0, 1);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            rst8    = (n == 0) || ($urandom_range(99) < 5);
            i8.en   = $urandom_range(9) < 8;
            i8.mode = 2'($urandom_range(3));
            i8.t    = 8'($urandom);
            case ($urandom_range(3))
                0:       i8.d = 8'hFF;
                1:       i8.d = 8'h00;
                default: i8.d = 8'($urandom);
            endcase
        end
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
